vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing_pkg.sv | 16 +
 rtl/vga_defines.sv | 22 ++
 rtl/vga_timing.sv | 106 ++++++++++
 tb/tb_vga_timing.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - counter widths and window helper for the VGA timing generator.
`include "vga_defines.sv"

package vga_timing_pkg;

  localparam int CNT_W = `VGA_HCOUNT_W;
  localparam int RGB_W = `VGA_RGB_W;

  // Half-open window [lo, hi) used for both sync pulses.
  function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/vga_defines.sv
// rtl/vga_defines.sv - shared VGA timing bus layout and game geometry macros.
`ifndef VGA_DEFINES_SV
`define VGA_DEFINES_SV

`define GAME_WIDTH       800
`define GAME_HEIGHT      600

`define VGA_BUS_SIZE     38

`define VGA_HCOUNT_W     11
`define VGA_VCOUNT_W     11
`define VGA_RGB_W        12

`define VGA_HCOUNT_RANGE 37:27
`define VGA_VCOUNT_RANGE 26:16
`define VGA_HSYNC_BIT    15
`define VGA_VSYNC_BIT    14
`define VGA_HBLNK_BIT    13
`define VGA_VBLNK_BIT    12
`define VGA_RGB_RANGE    11:0

`endif

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA pixel/line counters with registered sync, blank and rgb on a packed bus.
`include "vga_defines.sv"

module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int               H_VISIBLE = `GAME_WIDTH,
  parameter int               H_FRONT   = 40,
  parameter int               H_SYNC    = 128,
  parameter int               H_BACK    = 88,
  parameter int               V_VISIBLE = `GAME_HEIGHT,
  parameter int               V_FRONT   = 1,
  parameter int               V_SYNC    = 4,
  parameter int               V_BACK    = 23,
  parameter logic [RGB_W-1:0] BG_COLOUR = 12'h000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  output logic [`VGA_BUS_SIZE-1:0] vga_bus_out,
  output logic                     frame_tick
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_BLANK_AT = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] H_SYNC_ON  = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_OFF = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_BLANK_AT = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] V_SYNC_ON  = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_OFF = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             hblnk_q, hblnk_d;
  logic             vblnk_q, vblnk_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             frame_tick_q, frame_tick_d;

  // Flags are derived from the next counts so every bus field lines up in the same cycle.
  always_comb begin
    hcount_d     = hcount_q;
    vcount_d     = vcount_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    hblnk_d      = hblnk_q;
    vblnk_d      = vblnk_q;
    rgb_d        = rgb_q;
    frame_tick_d = 1'b0;
    if (en) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
      hblnk_d      = (hcount_d >= H_BLANK_AT);
      vblnk_d      = (vcount_d >= V_BLANK_AT);
      hsync_d      = in_window(hcount_d, H_SYNC_ON, H_SYNC_OFF);
      vsync_d      = in_window(vcount_d, V_SYNC_ON, V_SYNC_OFF);
      rgb_d        = (!hblnk_d && !vblnk_d) ? BG_COLOUR : '0;
      frame_tick_d = (hcount_d == '0) && (vcount_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_q     <= '0;
      vcount_q     <= '0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      hblnk_q      <= 1'b0;
      vblnk_q      <= 1'b0;
      rgb_q        <= BG_COLOUR;
      frame_tick_q <= 1'b0;
    end else begin
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      hblnk_q      <= hblnk_d;
      vblnk_q      <= vblnk_d;
      rgb_q        <= rgb_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  always_comb begin
    vga_bus_out                    = '0;
    vga_bus_out[`VGA_HCOUNT_RANGE] = hcount_q;
    vga_bus_out[`VGA_VCOUNT_RANGE] = vcount_q;
    vga_bus_out[`VGA_HSYNC_BIT]    = hsync_q;
    vga_bus_out[`VGA_VSYNC_BIT]    = vsync_q;
    vga_bus_out[`VGA_HBLNK_BIT]    = hblnk_q;
    vga_bus_out[`VGA_VBLNK_BIT]    = vblnk_q;
    vga_bus_out[`VGA_RGB_RANGE]    = rgb_q;
  end

  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - directed vector bench for vga_timing with a shortened vertical frame.
`include "vga_defines.sv"

module tb_vga_timing;

  // 13-line frame keeps full-frame runs short; lines 6..12 blank, 7..10 vsync.
  localparam int          V_TOT  = 13;
  localparam int          H_TOT  = 1056;
  localparam int          FRAME  = H_TOT * V_TOT;
  localparam logic [11:0] BG     = 12'hABC;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     en  = 1'b0;
  logic [`VGA_BUS_SIZE-1:0] bus;
  logic                     tick;

  vga_timing #(
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(4), .V_BACK(2), .BG_COLOUR(BG)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .vga_bus_out(bus), .frame_tick(tick)
  );

  always #5 clk = ~clk;

  logic [10:0] hc, vc;
  logic [11:0] rgb;
  logic        hs, vs, hb, vb;
  assign hc  = bus[`VGA_HCOUNT_RANGE];
  assign vc  = bus[`VGA_VCOUNT_RANGE];
  assign hs  = bus[`VGA_HSYNC_BIT];
  assign vs  = bus[`VGA_VSYNC_BIT];
  assign hb  = bus[`VGA_HBLNK_BIT];
  assign vb  = bus[`VGA_VBLNK_BIT];
  assign rgb = bus[`VGA_RGB_RANGE];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  function automatic logic [38:0] pack(input logic [10:0] h, input logic [10:0] v,
                                       input logic s_h, input logic s_v,
                                       input logic b_h, input logic b_v,
                                       input logic [11:0] c, input logic t);
    return {h, v, s_h, s_v, b_h, b_v, c, t};
  endfunction

  function automatic logic [38:0] actual();
    return {hc, vc, hs, vs, hb, vb, rgb, tick};
  endfunction

  typedef struct {
    int          n;
    logic [10:0] h;
    logic [10:0] v;
    logic        s_h, s_v, b_h, b_v;
    logic [11:0] c;
    logic        t;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int n;
    int ticks, tick_at_origin, vs_cycles, hs_cycles, hs_rise_h, vs_min, vs_max;
    logic prev_hs, frozen_ok;
    logic [`VGA_BUS_SIZE-1:0] snap;

    tbl[0]  = '{1,     11'd1,    11'd0,  0, 0, 0, 0, BG,     0};
    tbl[1]  = '{799,   11'd799,  11'd0,  0, 0, 0, 0, BG,     0};
    tbl[2]  = '{800,   11'd800,  11'd0,  0, 0, 1, 0, 12'h0,  0};
    tbl[3]  = '{839,   11'd839,  11'd0,  0, 0, 1, 0, 12'h0,  0};
    tbl[4]  = '{840,   11'd840,  11'd0,  1, 0, 1, 0, 12'h0,  0};
    tbl[5]  = '{967,   11'd967,  11'd0,  1, 0, 1, 0, 12'h0,  0};
    tbl[6]  = '{968,   11'd968,  11'd0,  0, 0, 1, 0, 12'h0,  0};
    tbl[7]  = '{1055,  11'd1055, 11'd0,  0, 0, 1, 0, 12'h0,  0};
    tbl[8]  = '{1056,  11'd0,    11'd1,  0, 0, 0, 0, BG,     0};
    tbl[9]  = '{6336,  11'd0,    11'd6,  0, 0, 0, 1, 12'h0,  0};
    tbl[10] = '{7392,  11'd0,    11'd7,  0, 1, 0, 1, 12'h0,  0};
    tbl[11] = '{11615, 11'd1055, 11'd10, 0, 1, 1, 1, 12'h0,  0};
    tbl[12] = '{11616, 11'd0,    11'd11, 0, 0, 0, 1, 12'h0,  0};
    tbl[13] = '{13727, 11'd1055, 11'd12, 0, 0, 1, 1, 12'h0,  0};
    tbl[14] = '{13728, 11'd0,    11'd0,  0, 0, 0, 0, BG,     1};
    tbl[15] = '{13729, 11'd1,    11'd0,  0, 0, 0, 0, BG,     0};

    #2 rst = 1'b0;
    run(3);
    check("reset_state", 64'(actual()), 64'(pack(11'd0, 11'd0, 0, 0, 0, 0, BG, 0)));
    rst = 1'b1;
    en  = 1'b1;

    n = 0;
    foreach (tbl[i]) begin
      while (n < tbl[i].n) begin
        step();
        n++;
      end
      check($sformatf("vec%0d_n%0d", i, tbl[i].n), 64'(actual()),
            64'(pack(tbl[i].h, tbl[i].v, tbl[i].s_h, tbl[i].s_v,
                     tbl[i].b_h, tbl[i].b_v, tbl[i].c, tbl[i].t)));
    end

    // One whole frame starting from (1,0).
    ticks = 0; tick_at_origin = 0; vs_cycles = 0; hs_cycles = 0;
    hs_rise_h = -1; vs_min = 9999; vs_max = -1; prev_hs = hs;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (tick) begin
        ticks++;
        if (hc == 11'd0 && vc == 11'd0) tick_at_origin++;
      end
      if (hs) hs_cycles++;
      if (hs && !prev_hs && hs_rise_h < 0) hs_rise_h = int'(hc);
      prev_hs = hs;
      if (vs) begin
        vs_cycles++;
        if (int'(vc) < vs_min) vs_min = int'(vc);
        if (int'(vc) > vs_max) vs_max = int'(vc);
      end
    end
    check("frame_tick_count",  64'(ticks), 64'd1);
    check("frame_tick_origin", 64'(tick_at_origin), 64'd1);
    check("hsync_cycles",      64'(hs_cycles), 64'(128 * V_TOT));
    check("hsync_rise_h",      64'(hs_rise_h), 64'd840);
    check("vsync_cycles",      64'(vs_cycles), 64'(4 * H_TOT));
    check("vsync_lines",       64'({vs_min[15:0], vs_max[15:0]}), 64'({16'd7, 16'd10}));

    // Hold en low on the last pixel of the frame.
    run(FRAME - 2);
    check("pre_freeze_pos", 64'({hc, vc}), 64'({11'd1055, 11'd12}));
    en = 1'b0;
    snap = bus;
    frozen_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (bus !== snap || tick !== 1'b0) frozen_ok = 1'b0;
    end
    check("freeze_50", 64'(frozen_ok), 64'd1);
    en = 1'b1;
    step();
    check("resume_wrap", 64'(actual()), 64'(pack(11'd0, 11'd0, 0, 0, 0, 0, BG, 1)));
    step();
    check("resume_next", 64'({hc, vc, tick}), 64'({11'd1, 11'd0, 1'b0}));

    // Reset in the middle of both sync pulses.
    run(8 * H_TOT + 900 - 1);
    check("pre_reset_pos", 64'(actual()), 64'(pack(11'd900, 11'd8, 1, 1, 1, 1, 12'h0, 0)));
    #2 rst = 1'b0;
    #1;
    check("async_reset", 64'(actual()), 64'(pack(11'd0, 11'd0, 0, 0, 0, 0, BG, 0)));
    step();
    rst = 1'b1;
    step();
    check("post_reset_first", 64'(actual()), 64'(pack(11'd1, 11'd0, 0, 0, 0, 0, BG, 0)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
